// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and defaults for the PISO serializer
package piso_pkg;

    // Serializer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } piso_state_e;

    // Word width of the downstream SIPO deserializer this block feeds
    localparam int WORD_W_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count, full and empty
module sync_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Overflow/underflow requests are ignored so the pointers never desync
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - FIFO-buffered MSB-first serializer with optional idle gap
module piso_serializer #(
    parameter int WIDTH = piso_pkg::WORD_W_DEFAULT,
    parameter int DEPTH = 2,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p_in,
    output logic             out_valid,
    output logic             s_out,
    output logic             busy
);

    import piso_pkg::*;

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;

    logic             in_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    assign in_push = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_push),
        .push_data (p_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Every output comes from registered state only
    assign in_ready  = !fifo_full;
    assign out_valid = (state_q == SHIFT);
    assign s_out     = out_valid && shift_q[WIDTH-1];
    assign busy      = (state_q != IDLE) || (fifo_count != '0);

    // Control: load a word, shift it out MSB first, then optionally idle for GAP cycles
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = piso_pkg::GAP;
                    end else if (!fifo_empty) begin
                        // Chain the next word with no bubble
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            piso_pkg::GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        bit_cnt_d = '0;
                        state_d   = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and counters; reset drops any partial word at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer at GAP 0, 1 and 2
module tb_piso_serializer;

    localparam int W    = 4;
    localparam int D    = 2;
    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv  [NDUT];
    logic [W-1:0] pin [NDUT];
    logic         ir  [NDUT];
    logic         ov  [NDUT];
    logic         so  [NDUT];
    logic         bz  [NDUT];

    int total = 0;
    int bad   = 0;
    int vprob = 100;

    logic [W-1:0] stim_q    [NDUT][$];
    logic [W-1:0] mfifo     [NDUT][$];
    logic [W-1:0] exp_words [NDUT][$];
    logic [1:0]   sched     [NDUT][$];

    logic [W-1:0] mon_word [NDUT];
    int           mon_bits [NDUT];
    int           accepted [NDUT];
    int           received [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        piso_serializer #(
            .WIDTH (W),
            .DEPTH (D),
            .GAP   (g)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .p_in      (pin[g]),
            .out_valid (ov[g]),
            .s_out     (so[g]),
            .busy      (bz[g])
        );
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s gap%0d: got %0h want %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input int d);
        logic [1:0] cur;
        cur = (sched[d].size() != 0) ? sched[d][0] : 2'b00;
        chk("out_valid", d, ov[d], cur[1]);
        chk("s_out", d, so[d], cur[0]);
        chk("in_ready", d, ir[d], mfifo[d].size() != D);
        chk("busy", d, bz[d], (sched[d].size() != 0) || (mfifo[d].size() != 0));
    endtask

    // Reference: a timeline of committed output cycles; a queued word is
    // committed (WIDTH data bits then d idle cycles) as soon as the timeline runs dry.
    task automatic model_step(input int d);
        logic         acc;
        logic [W-1:0] w;
        acc = iv[d] && (mfifo[d].size() != D);
        if (sched[d].size() != 0) void'(sched[d].pop_front());
        if (sched[d].size() == 0 && mfifo[d].size() != 0) begin
            w = mfifo[d].pop_front();
            for (int b = W - 1; b >= 0; b--) sched[d].push_back({1'b1, w[b]});
            for (int k = 0; k < d; k++) sched[d].push_back(2'b00);
        end
        if (acc) begin
            mfifo[d].push_back(pin[d]);
            exp_words[d].push_back(pin[d]);
            void'(stim_q[d].pop_front());
            accepted[d]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_outputs(d);
        for (int d = 0; d < NDUT; d++) begin
            iv[d]  = (stim_q[d].size() != 0) && ($urandom_range(99) < vprob);
            pin[d] = iv[d] ? stim_q[d][0] : W'($urandom);
            model_step(d);
        end
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < NDUT; d++)
            if (stim_q[d].size() != 0 || mfifo[d].size() != 0 || sched[d].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (!all_idle() && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain: still busy after %0d cycles, want idle", n);
        end
        repeat (3) tick();
    endtask

    task automatic push_all(input logic [W-1:0] w);
        for (int d = 0; d < NDUT; d++) stim_q[d].push_back(w);
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++) begin
            stim_q[d].delete();
            mfifo[d].delete();
            exp_words[d].delete();
            sched[d].delete();
            mon_bits[d] = 0;
            accepted[d] = 0;
            received[d] = 0;
            iv[d]       = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_out_valid", d, ov[d], 1'b0);
            chk("rst_s_out", d, so[d], 1'b0);
            chk("rst_busy", d, bz[d], 1'b0);
            chk("rst_in_ready", d, ir[d], 1'b1);
        end
    endtask

    // Deserializing monitor: every WIDTH valid bits form a word that must match the next accepted one
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                if (ov[d]) begin
                    mon_word[d] = {mon_word[d][W-2:0], so[d]};
                    mon_bits[d]++;
                    if (mon_bits[d] == W) begin
                        mon_bits[d] = 0;
                        received[d]++;
                        if (exp_words[d].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL word gap%0d: got %0h, want no word", d, mon_word[d]);
                        end else begin
                            chk("word", d, mon_word[d], exp_words[d].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            pin[d]      = '0;
            mon_word[d] = '0;
        end
        clear_model();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single word
        push_all(4'b1011);
        drain();

        // Back-to-back words
        push_all(4'hA);
        push_all(4'h5);
        drain();

        // Backpressure: four words held on in_valid against a two-entry FIFO
        push_all(4'hA);
        push_all(4'hB);
        push_all(4'hC);
        push_all(4'hD);
        drain();

        // Gap behaviour with contrasting words
        push_all(4'hF);
        push_all(4'h0);
        drain();

        // Reset after two bits of a word
        push_all(4'hC);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ov[0] && n < 10);
        chk("first_bit_seen", 0, ov[0], 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        push_all(4'h3);
        drain();

        // Random words at varying offered load
        for (int r = 0; r < 6; r++) begin
            vprob = 20 + 16 * r;
            for (int k = 0; k < 40; k++) begin
                for (int d = 0; d < NDUT; d++) stim_q[d].push_back(W'($urandom));
            end
            drain();
        end

        for (int d = 0; d < NDUT; d++) begin
            chk("leftover_words", d, exp_words[d].size(), 0);
            chk("word_count", d, received[d], accepted[d]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
